// File: rtl/atm_pkg.sv
// Shared types and constants for the ATM note dispenser.
//   state_e   : dispenser FSM states (S_FAULT only with JAM_DETECT_EN)
//   amount_t  : 16-bit unsigned currency amount
//   DENOM*    : default note values per cassette (cassette 3 is the largest)
//   NOTE_*    : one-hot note_sel codes per cassette
// Optional feature macro: JAM_DETECT_EN
package atm_pkg;

  typedef logic [15:0] amount_t;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PLAN     = 3'd1,
    S_DISPENSE = 3'd2,
    S_GAP      = 3'd3,
    S_DONE     = 3'd4,
    S_REJECT   = 3'd5
`ifdef JAM_DETECT_EN
    , S_FAULT  = 3'd6
`endif
  } state_e;

  localparam int unsigned DENOM3_DEF = 2000;
  localparam int unsigned DENOM2_DEF = 500;
  localparam int unsigned DENOM1_DEF = 200;
  localparam int unsigned DENOM0_DEF = 100;

  localparam logic [3:0] NOTE_2000 = 4'b1000;
  localparam logic [3:0] NOTE_500  = 4'b0100;
  localparam logic [3:0] NOTE_200  = 4'b0010;
  localparam logic [3:0] NOTE_100  = 4'b0001;

endpackage

// File: rtl/atm_cassette_counter.sv
// Inventory register for one note cassette.
//   clk_i, reset_i : clock, synchronous active-high reset (count -> 0)
//   load_en_i      : overwrite count with load_count_i
//   dec_en_i       : remove one note (never asserted when count is 0)
//   count_o        : current note count
//   low_o          : registered flag, count < LOW_THRESH
module atm_cassette_counter #(
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned LOW_THRESH = 5
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_en_i,
  input  logic [CNT_W-1:0] load_count_i,
  input  logic             dec_en_i,
  output logic [CNT_W-1:0] count_o,
  output logic             low_o
);

  localparam logic [CNT_W-1:0] LOW_T = CNT_W'(LOW_THRESH);

  logic [CNT_W-1:0] count_q, count_d;
  logic             low_q;

  always_comb begin
    count_d = count_q;
    if (load_en_i) begin
      count_d = load_count_i;
    end else if (dec_en_i) begin
      count_d = count_q - 1'b1;
    end
  end

  // Low flag is derived from the next count so it tracks the register exactly.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
      low_q   <= (LOW_T != '0);
    end else begin
      count_q <= count_d;
      low_q   <= (count_d < LOW_T);
    end
  end

  assign count_o = count_q;
  assign low_o   = low_q;

endmodule

// File: rtl/atm_note_dispenser.sv
// Cash-dispense stage: accepts an approved amount, plans a greedy note
// breakdown against cassette inventory, then pulses the dispenser one note
// at a time and reports done or reject.
//   clk, reset          : clock, synchronous active-high reset
//   req_valid/req_amount/req_ready : withdrawal request handshake
//   load_en/load_sel/load_count    : cassette refill (IDLE only)
//   note_pulse/note_sel : one-cycle eject command with one-hot cassette
//   done/reject         : one-cycle transaction result pulses
//   dispensed_amount    : running total of current or last transaction
//   low_cash            : per-cassette low-inventory flags
//   note_seen/jam       : only with JAM_DETECT_EN (eject confirm, jam fault)
// Optional feature macro: JAM_DETECT_EN
module atm_note_dispenser
  import atm_pkg::*;
#(
  parameter int unsigned DENOM3       = DENOM3_DEF,
  parameter int unsigned DENOM2       = DENOM2_DEF,
  parameter int unsigned DENOM1       = DENOM1_DEF,
  parameter int unsigned DENOM0       = DENOM0_DEF,
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned MAX_WITHDRAW = 20000,
  parameter int unsigned GAP_CYCLES   = 4,
  parameter int unsigned LOW_THRESH   = 5,
  parameter int unsigned JAM_TIMEOUT  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [15:0]      req_amount,
  output logic             req_ready,
  input  logic             load_en,
  input  logic [1:0]       load_sel,
  input  logic [CNT_W-1:0] load_count,
  output logic             note_pulse,
  output logic [3:0]       note_sel,
  output logic             done,
  output logic             reject,
  output logic [15:0]      dispensed_amount,
  output logic [3:0]       low_cash
`ifdef JAM_DETECT_EN
  ,
  input  logic             note_seen,
  output logic             jam
`endif
);

  localparam int unsigned CNT_MAX = (JAM_TIMEOUT > GAP_CYCLES) ? JAM_TIMEOUT : GAP_CYCLES;
  localparam int unsigned GAP_W   = $clog2(CNT_MAX + 1);
  localparam logic [GAP_W-1:0] GAP_LIM = GAP_W'(GAP_CYCLES);
`ifdef JAM_DETECT_EN
  localparam logic [GAP_W-1:0] JAM_LIM = GAP_W'(JAM_TIMEOUT - 1);
  localparam logic [GAP_W-1:0] CNT_TOP = GAP_W'(CNT_MAX);
`endif
  localparam amount_t MAX_AMT = amount_t'(MAX_WITHDRAW);
  // Index order matches note_sel bit order: index 3 is the largest note.
  localparam amount_t DEN [4] = '{amount_t'(DENOM0), amount_t'(DENOM1),
                                  amount_t'(DENOM2), amount_t'(DENOM3)};

  state_e           state_q;
  amount_t          remaining_q;
  amount_t          disp_q;
  logic [GAP_W-1:0] gap_q;
  logic [CNT_W-1:0] plan_q [4];
  logic             note_pulse_q;
  logic [3:0]       note_sel_q;
  logic             done_q;
  logic             reject_q;
`ifdef JAM_DETECT_EN
  logic             seen_q;
  logic             jam_q;
`endif

  logic [CNT_W-1:0] inv_cnt [4];
  logic [3:0]       dec_en;
  logic [3:0]       plan_sel;
  amount_t          plan_den;
  logic [3:0]       disp_sel;
  amount_t          pulse_den;

  // Ascending scans: a later (larger) hit overwrites, so the largest wins.
  always_comb begin
    plan_sel  = '0;
    plan_den  = '0;
    disp_sel  = '0;
    pulse_den = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      if (DEN[k] <= remaining_q && plan_q[k] < inv_cnt[k]) begin
        plan_sel    = '0;
        plan_sel[k] = 1'b1;
        plan_den    = DEN[k];
      end
      if (plan_q[k] != '0) begin
        disp_sel    = '0;
        disp_sel[k] = 1'b1;
      end
      if (note_sel_q[k]) begin
        pulse_den = DEN[k];
      end
    end
  end

  // The eject command is registered on the edge that enters DISPENSE, so the
  // pulse is visible during the DISPENSE cycle that consumes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      remaining_q  <= '0;
      disp_q       <= '0;
      gap_q        <= '0;
      note_pulse_q <= 1'b0;
      note_sel_q   <= '0;
      done_q       <= 1'b0;
      reject_q     <= 1'b0;
      for (int unsigned k = 0; k < 4; k++) plan_q[k] <= '0;
`ifdef JAM_DETECT_EN
      seen_q       <= 1'b0;
      jam_q        <= 1'b0;
`endif
    end else begin
      note_pulse_q <= 1'b0;
      note_sel_q   <= '0;
      done_q       <= 1'b0;
      reject_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            remaining_q <= req_amount;
            disp_q      <= '0;
            for (int unsigned k = 0; k < 4; k++) plan_q[k] <= '0;
            if (req_amount == '0 || req_amount > MAX_AMT) begin
              state_q  <= S_REJECT;
              reject_q <= 1'b1;
            end else begin
              state_q <= S_PLAN;
            end
          end
        end
        S_PLAN: begin
          if (remaining_q == '0) begin
            state_q      <= S_DISPENSE;
            note_pulse_q <= |disp_sel;
            note_sel_q   <= disp_sel;
          end else if (plan_sel != '0) begin
            remaining_q <= remaining_q - plan_den;
            for (int unsigned k = 0; k < 4; k++) begin
              if (plan_sel[k]) plan_q[k] <= plan_q[k] + 1'b1;
            end
          end else begin
            state_q  <= S_REJECT;
            reject_q <= 1'b1;
          end
        end
        S_DISPENSE: begin
          if (note_pulse_q) begin
            for (int unsigned k = 0; k < 4; k++) begin
              if (note_sel_q[k]) plan_q[k] <= plan_q[k] - 1'b1;
            end
            disp_q  <= disp_q + pulse_den;
            gap_q   <= GAP_W'(1);
            state_q <= S_GAP;
`ifdef JAM_DETECT_EN
            seen_q  <= 1'b0;
`endif
          end else begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_GAP: begin
`ifdef JAM_DETECT_EN
          if (note_seen) seen_q <= 1'b1;
          if (gap_q >= GAP_LIM && (seen_q || note_seen)) begin
            state_q      <= S_DISPENSE;
            note_pulse_q <= |disp_sel;
            note_sel_q   <= disp_sel;
          end else if (gap_q == JAM_LIM && !(seen_q || note_seen)) begin
            state_q <= S_FAULT;
            jam_q   <= 1'b1;
          end else if (gap_q != CNT_TOP) begin
            gap_q <= gap_q + 1'b1;
          end
`else
          if (gap_q == GAP_LIM) begin
            state_q      <= S_DISPENSE;
            note_pulse_q <= |disp_sel;
            note_sel_q   <= disp_sel;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
`endif
        end
        S_DONE:   state_q <= S_IDLE;
        S_REJECT: state_q <= S_IDLE;
`ifdef JAM_DETECT_EN
        S_FAULT:  state_q <= S_FAULT;
`endif
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  assign dec_en = {4{state_q == S_DISPENSE && note_pulse_q}} & note_sel_q;

  for (genvar g = 0; g < 4; g++) begin : g_cas
    atm_cassette_counter #(
      .CNT_W      (CNT_W),
      .LOW_THRESH (LOW_THRESH)
    ) u_cas (
      .clk_i        (clk),
      .reset_i      (reset),
      .load_en_i    (load_en && state_q == S_IDLE && load_sel == 2'(g)),
      .load_count_i (load_count),
      .dec_en_i     (dec_en[g]),
      .count_o      (inv_cnt[g]),
      .low_o        (low_cash[g])
    );
  end

  assign req_ready        = (state_q == S_IDLE);
  assign note_pulse       = note_pulse_q;
  assign note_sel         = note_sel_q;
  assign done             = done_q;
  assign reject           = reject_q;
  assign dispensed_amount = disp_q;
`ifdef JAM_DETECT_EN
  assign jam              = jam_q;
`endif

endmodule

// File: tb/tb_atm_note_dispenser.sv
// Self-checking bench for atm_note_dispenser (default build). A reference
// model computes the greedy breakdown arithmetically from inventory and
// predicts outcome, pulse order/timing, totals and low-cash flags.
module tb_atm_note_dispenser;

  localparam int GAP = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [15:0] req_amount;
  logic        req_ready;
  logic        load_en;
  logic [1:0]  load_sel;
  logic [7:0]  load_count;
  logic        note_pulse;
  logic [3:0]  note_sel;
  logic        done;
  logic        reject;
  logic [15:0] dispensed_amount;
  logic [3:0]  low_cash;

  always #5 clk = ~clk;

  atm_note_dispenser dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_amount       (req_amount),
    .req_ready        (req_ready),
    .load_en          (load_en),
    .load_sel         (load_sel),
    .load_count       (load_count),
    .note_pulse       (note_pulse),
    .note_sel         (note_sel),
    .done             (done),
    .reject           (reject),
    .dispensed_amount (dispensed_amount),
    .low_cash         (low_cash)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int inv [4];
  int den [4] = '{100, 200, 500, 2000};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] model_low();
    logic [3:0] lc;
    for (int i = 0; i < 4; i++) lc[i] = (inv[i] < 5);
    return lc;
  endfunction

  task automatic load(input int sel, input int cnt);
    load_en    = 1'b1;
    load_sel   = sel[1:0];
    load_count = cnt[7:0];
    tick();
    load_en = 1'b0;
    inv[sel] = cnt;
  endtask

  task automatic do_req(input int amt, input bit with_load, input int lsel,
                        input int lcnt, input bit busy_load);
    int exp_sel[$];
    int got_sel[$];
    int got_rel[$];
    int k, rem, n, out_rel;
    bit exp_rej, got_done, got_rej, sel_bad;
    int exp_rej_rel;

    // A refill in the handshake cycle lands before planning starts.
    if (with_load) inv[lsel] = lcnt;
    rem = amt;
    k   = 0;
    if (amt == 0 || amt > 20000) begin
      exp_rej     = 1'b1;
      exp_rej_rel = 1;
    end else begin
      for (int i = 3; i >= 0; i--) begin
        n = rem / den[i];
        if (n > inv[i]) n = inv[i];
        rem -= n * den[i];
        k   += n;
        repeat (n) exp_sel.push_back(1 << i);
      end
      exp_rej     = (rem != 0);
      exp_rej_rel = k + 2;
    end

    check("req_ready_idle", req_ready, 1);
    req_valid  = 1'b1;
    req_amount = amt[15:0];
    load_en    = with_load;
    load_sel   = lsel[1:0];
    load_count = lcnt[7:0];
    tick();
    req_valid = 1'b0;
    load_en   = 1'b0;

    got_done = 1'b0;
    got_rej  = 1'b0;
    sel_bad  = 1'b0;
    out_rel  = 0;
    for (int rel = 1; rel <= 2000; rel++) begin
      if (note_pulse) begin
        got_sel.push_back(int'(note_sel));
        got_rel.push_back(rel);
      end else if (note_sel != 4'b0000) begin
        sel_bad = 1'b1;
      end
      if (done || reject) begin
        got_done = done;
        got_rej  = reject;
        out_rel  = rel;
        break;
      end
      // Refill attempts while busy must be ignored by the DUT.
      if (busy_load) begin
        load_en    = 1'($urandom_range(0, 1));
        load_sel   = 2'($urandom_range(0, 3));
        load_count = 8'($urandom_range(0, 255));
      end
      tick();
    end
    load_en = 1'b0;

    if (!got_done && !got_rej) check("result_timeout", 0, 1);
    if (exp_rej) begin
      check("reject_seen", got_rej, 1);
      check("reject_cycle", out_rel, exp_rej_rel);
      check("reject_no_pulses", got_sel.size(), 0);
      check("reject_dispensed", dispensed_amount, 0);
    end else begin
      check("done_seen", got_done, 1);
      check("done_cycle", out_rel, k + 2 + (GAP + 1) * k + 1);
      check("pulse_count", got_sel.size(), exp_sel.size());
      for (int j = 0; j < got_sel.size() && j < exp_sel.size(); j++) begin
        check("pulse_sel", got_sel[j], exp_sel[j]);
        check("pulse_cycle", got_rel[j], k + 2 + (GAP + 1) * j);
      end
      check("done_dispensed", dispensed_amount, amt);
      for (int i = 0; i < 4; i++) begin
        n = 0;
        foreach (exp_sel[j]) if (exp_sel[j] == (1 << i)) n++;
        inv[i] -= n;
      end
    end
    check("note_sel_idle_zero", sel_bad, 0);
    tick();
    check("req_ready_after", req_ready, 1);
    check("low_cash", low_cash, model_low());
  endtask

  initial begin
    bit found, bad;
    int amt, pick;

    reset      = 1'b1;
    req_valid  = 1'b0;
    req_amount = '0;
    load_en    = 1'b0;
    load_sel   = '0;
    load_count = '0;
    for (int i = 0; i < 4; i++) inv[i] = 0;
    tick();
    tick();
    check("rst_req_ready", req_ready, 1);
    check("rst_low_cash", low_cash, 4'b1111);
    check("rst_note_pulse", note_pulse, 0);
    check("rst_note_sel", note_sel, 0);
    check("rst_done", done, 0);
    check("rst_reject", reject, 0);
    check("rst_dispensed", dispensed_amount, 0);
    reset = 1'b0;
    tick();

    // Directed cases
    load(3, 2); load(2, 4); load(1, 5); load(0, 10);
    do_req(2700, 0, 0, 0, 0);
    do_req(150, 0, 0, 0, 0);
    do_req(0, 0, 0, 0, 0);
    do_req(25000, 0, 0, 0, 0);
    do_req(20100, 0, 0, 0, 0);
    do_req(20000, 0, 0, 0, 0);
    load(3, 0); load(2, 1); load(1, 3); load(0, 0);
    do_req(600, 0, 0, 0, 0);
    do_req(1100, 0, 0, 0, 1);
    load(3, 10);
    do_req(20000, 0, 0, 0, 0);
    do_req(300, 1, 0, 7, 0);

    // Randomized cases
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 1) == 1) load($urandom_range(0, 3), $urandom_range(0, 12));
      pick = $urandom_range(0, 3);
      case (pick)
        0: amt = $urandom_range(0, 60) * 100;
        1: amt = $urandom_range(0, 25000);
        2: amt = $urandom_range(0, 200) * 100;
        default: begin
          case ($urandom_range(0, 3))
            0: amt = 0;
            1: amt = 20000;
            2: amt = 20100;
            default: amt = 100;
          endcase
        end
      endcase
      do_req(amt, 1'($urandom_range(0, 2) == 0), $urandom_range(0, 3),
             $urandom_range(0, 12), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a dispense
    load(3, 2); load(2, 4); load(1, 5); load(0, 10);
    req_valid  = 1'b1;
    req_amount = 16'd2700;
    tick();
    req_valid = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (note_pulse) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("midrst_first_pulse", found, 1);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) inv[i] = 0;
    check("midrst_note_pulse", note_pulse, 0);
    check("midrst_note_sel", note_sel, 0);
    check("midrst_done", done, 0);
    check("midrst_reject", reject, 0);
    check("midrst_dispensed", dispensed_amount, 0);
    check("midrst_req_ready", req_ready, 1);
    check("midrst_low_cash", low_cash, 4'b1111);
    bad = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (done || reject || note_pulse) bad = 1'b1;
      tick();
    end
    check("midrst_no_activity", bad, 0);
    do_req(100, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
